mul_32_seq: RTL and testbench

- Iterative shift-and-add 32x32 multiplier for the ALU datapath.
- Each RUN cycle issues one 32-bit partial-sum addition (a + b + carry-in, carry-out kept) to a ripple-carry 32-bit adder stage.
- That adder stage is instantiated inside this block; this block sequences its operands and captures its sum and carry.
- Delivers a registered 64-bit product plus an overflow flag under a start/busy/done handshake; supports unsigned and two's-complement signed operands.

---
 rtl/mul_32_seq.sv | 151 +++++++++++++++
 tb/tb_mul_32_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_32_seq.sv
// Iterative shift-and-add multiplier: one partial-sum add per RUN cycle through a
// local ripple-carry adder, registered 2*WIDTH product plus overflow flag.

module mul_32_seq_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    always_comb begin : ripple
        logic w_c;
        w_c   = i_cin;
        o_sum = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
            w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
        end
        o_cout = w_c;
    end

endmodule

module mul_32_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_load;
    logic               w_last;

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg;
    logic               r_signed;

    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_add_b;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_prod_final;
    logic               w_ovf_final;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_last       = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_last       = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
    assign w_b_mag = (is_signed && b[WIDTH-1]) ? -b : b;
    assign w_add_b = r_acc[0] ? r_mcand : '0;

    mul_32_seq_adder #(.WIDTH(WIDTH)) u_adder (
        .i_a    (r_acc[2*WIDTH-1:WIDTH]),
        .i_b    (w_add_b),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Carry-out re-enters as the MSB of the right-shifted accumulator.
    assign w_acc_next   = {w_cout, w_sum, r_acc[WIDTH-1:1]};
    assign w_prod_final = r_neg ? -w_acc_next : w_acc_next;
    assign w_ovf_final  = r_signed
        ? (w_prod_final[2*WIDTH-1:WIDTH] != {WIDTH{w_prod_final[WIDTH-1]}})
        : (|w_prod_final[2*WIDTH-1:WIDTH]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_signed <= 1'b0;
            product  <= '0;
            overflow <= 1'b0;
        end else if (w_load) begin
            r_acc    <= {{WIDTH{1'b0}}, w_b_mag};
            r_mcand  <= w_a_mag;
            r_cnt    <= '0;
            r_neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_signed <= is_signed;
        end else if (r_state == S_RUN) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                product  <= w_prod_final;
                overflow <= w_ovf_final;
            end
        end
    end

endmodule

// File: tb/tb_mul_32_seq.sv
// Directed-vector bench for mul_32_seq: table of hand-computed products, handshake
// corner sequences, reset abort and a short random sweep against a native multiply.

module tb_mul_32_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic        overflow;

    int n_err    = 0;
    int n_checks = 0;

    mul_32_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .product   (product),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] va;
        logic [31:0] vb;
        logic [63:0] prod;
        logic        ovf;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one operation, optionally scrambling inputs during RUN, and check the result.
    task automatic run_op(input logic s, input logic [31:0] av, input logic [31:0] bv,
                          input logic [63:0] ep, input logic eo, input bit scramble);
        int lat;
        int nbusy;
        @(posedge clk); #1;
        start = 1'b1; is_signed = s; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 0;
        nbusy = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (busy) nbusy++;
            if (scramble) begin
                a = $urandom; b = $urandom; is_signed = 1'($urandom_range(0, 1));
            end
        end
        chk("latency", 64'(lat), 64'd33);
        chk("busy_cycles", 64'(nbusy), 64'd32);
        chk("product", product, ep);
        chk("overflow", 64'(overflow), 64'(eo));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          ndone;
        int          first_done;
        int          holdbad;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0] ref_p;
        logic        ref_o;

        vecs[0]  = '{1'b0, 32'd7,        32'd6,        64'h0000_0000_0000_002A, 1'b0};
        vecs[1]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFF_FFFE_0000_0001, 1'b1};
        vecs[2]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000_0000_0000_0001, 1'b0};
        vecs[3]  = '{1'b1, 32'hFFFFFFFD, 32'd5,        64'hFFFF_FFFF_FFFF_FFF1, 1'b0};
        vecs[4]  = '{1'b1, 32'h80000000, 32'h80000000, 64'h4000_0000_0000_0000, 1'b1};
        vecs[5]  = '{1'b0, 32'd0,        32'h12345678, 64'h0000_0000_0000_0000, 1'b0};
        vecs[6]  = '{1'b0, 32'h00010000, 32'h00010000, 64'h0000_0001_0000_0000, 1'b1};
        vecs[7]  = '{1'b0, 32'h0000FFFF, 32'h0000FFFF, 64'h0000_0000_FFFE_0001, 1'b0};
        vecs[8]  = '{1'b1, 32'h80000000, 32'd1,        64'hFFFF_FFFF_8000_0000, 1'b0};
        vecs[9]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h0000_0000_8000_0000, 1'b1};
        vecs[10] = '{1'b0, 32'hFFFFFFFF, 32'd2,        64'h0000_0001_FFFF_FFFE, 1'b1};
        vecs[11] = '{1'b1, 32'd7,        32'hFFFFFFFA, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0};
        vecs[12] = '{1'b0, 32'hDEADBEEF, 32'd1,        64'h0000_0000_DEAD_BEEF, 1'b0};
        vecs[13] = '{1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFF_FFFF_0000_0001, 1'b1};

        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_product", product, 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++)
            run_op(vecs[i].sgn, vecs[i].va, vecs[i].vb, vecs[i].prod, vecs[i].ovf, (i % 2) == 1);

        // start pulses at cycles 5 and 10 of RUN are ignored
        @(posedge clk); #1;
        start = 1'b1; is_signed = 1'b0; a = 32'd7; b = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        first_done = 0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (first_done == 0) first_done = k;
            end
            if (k == 5 || k == 10) begin
                start = 1'b1; a = 32'd100; b = 32'd100;
            end else begin
                start = 1'b0;
            end
        end
        chk("ignored_start_done_count", 64'(ndone), 64'd1);
        chk("ignored_start_done_cycle", 64'(first_done), 64'd33);
        chk("ignored_start_product", product, 64'h2A);

        // start held in DONE: back-to-back, old product held until the next done
        run_op(1'b0, 32'h0000FFFF, 32'h0000FFFF, 64'h0000_0000_FFFE_0001, 1'b0, 1'b0);
        start = 1'b1; is_signed = 1'b0; a = 32'd3; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        first_done = 0;
        holdbad = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) chk("b2b_busy_no_idle", 64'(busy), 64'd1);
            if (done) begin
                first_done = k;
                break;
            end
            if (product !== 64'h0000_0000_FFFE_0001) holdbad++;
        end
        chk("b2b_done_cycle", 64'(first_done), 64'd33);
        chk("b2b_product_hold", 64'(holdbad), 64'd0);
        chk("b2b_product", product, 64'd15);

        // reset mid-RUN aborts with no done pulse
        @(posedge clk); #1;
        start = 1'b1; is_signed = 1'b0; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 15; k++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_product", product, 64'd0);
        chk("abort_overflow", 64'(overflow), 64'd0);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("abort_no_activity", 64'(ndone), 64'd0);

        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (i % 4 == 0) ra = ra & 32'h0000_00FF;
            if (rs) begin
                sa    = $signed(ra);
                sb    = $signed(rb);
                ref_p = sa * sb;
                ref_o = ($signed(ref_p) > 64'sh0000_0000_7FFF_FFFF) ||
                        ($signed(ref_p) < -64'sh0000_0000_8000_0000);
            end else begin
                ref_p = {32'd0, ra} * {32'd0, rb};
                ref_o = ref_p > 64'h0000_0000_FFFF_FFFF;
            end
            run_op(rs, ra, rb, ref_p, ref_o, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
